// File: rtl/gaussian_window_ctrl.sv
`default_nettype none
// ============================================================================
// gaussian_window_ctrl : raster-scan read/write address controller for K x K
// sliding-window filters.   Revision: 1.0
// ============================================================================
module gaussian_window_ctrl #(
  parameter int ADDRLEN  = 21,
  parameter int DIMLEN   = 11,
  parameter int KSIZE    = 7,
  parameter int RD_LAT   = 1,
  parameter int CORE_LAT = 1,
  parameter int CNTLEN   = 21
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               pause,
  input  logic [DIMLEN-1:0]  cfg_rows,
  input  logic [DIMLEN-1:0]  cfg_cols,
  input  logic [ADDRLEN-1:0] cfg_rd_base,
  input  logic [ADDRLEN-1:0] cfg_wr_base,
  output logic               rd_en,
  output logic [ADDRLEN-1:0] rd_addr,
  output logic               wr_en,
  output logic [ADDRLEN-1:0] wr_addr,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [CNTLEN-1:0]  win_count
);

  localparam int HALF = (KSIZE - 1) / 2;
  localparam int LAT  = RD_LAT + CORE_LAT;
  localparam int DCW  = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [DIMLEN-1:0] KDIM = DIMLEN'(KSIZE);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state_q;
  logic               run_q;
  logic               busy_q;
  logic               done_q;
  logic               err_q;
  logic [DIMLEN-1:0]  i_q;
  logic [DIMLEN-1:0]  j_q;
  logic [DIMLEN-1:0]  ilim_q;
  logic [DIMLEN-1:0]  jlim_q;
  logic [ADDRLEN-1:0] cols_q;
  logic [ADDRLEN-1:0] rrow_q;
  logic [ADDRLEN-1:0] raddr_q;
  logic [ADDRLEN-1:0] off_q;
  logic [DCW-1:0]     drain_q;
  logic [CNTLEN-1:0]  cnt_q;
  logic [LAT-1:0]     vld_q;
  logic [ADDRLEN-1:0] wa_q [LAT];

  logic [ADDRLEN-1:0] cols_ext_d;
  logic [ADDRLEN-1:0] off_d;
  logic [ADDRLEN-1:0] row_next_d;
  logic               issue_d;
  logic               last_col_d;
  logic               last_pos_d;
  logic               cfg_ok_d;

  // Write address = read address + constant offset; HALF*cols built from adds.
  always_comb begin
    cols_ext_d = ADDRLEN'(cfg_cols);
    off_d      = cfg_wr_base - cfg_rd_base + ADDRLEN'(HALF);
    for (int k = 0; k < HALF; k++) begin
      off_d = off_d + cols_ext_d;
    end
  end

  assign issue_d    = run_q & ~pause;
  assign last_col_d = (j_q == jlim_q);
  assign last_pos_d = last_col_d && (i_q == ilim_q);
  assign row_next_d = rrow_q + cols_q;
  assign cfg_ok_d   = (cfg_rows >= KDIM) && (cfg_cols >= KDIM);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      run_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      i_q     <= '0;
      j_q     <= '0;
      ilim_q  <= '0;
      jlim_q  <= '0;
      cols_q  <= '0;
      rrow_q  <= '0;
      raddr_q <= '0;
      off_q   <= '0;
      drain_q <= '0;
      cnt_q   <= '0;
    end else begin
      done_q <= 1'b0;
      if (vld_q[LAT-1]) begin
        cnt_q <= cnt_q + CNTLEN'(1);
      end
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            cnt_q   <= '0;
            cols_q  <= cols_ext_d;
            ilim_q  <= cfg_rows - KDIM;
            jlim_q  <= cfg_cols - KDIM;
            rrow_q  <= cfg_rd_base;
            raddr_q <= cfg_rd_base;
            off_q   <= off_d;
            i_q     <= '0;
            j_q     <= '0;
            if (cfg_ok_d) begin
              state_q <= S_RUN;
              run_q   <= 1'b1;
              busy_q  <= 1'b1;
              err_q   <= 1'b0;
            end else begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (issue_d) begin
            if (last_pos_d) begin
              state_q <= S_DRAIN;
              run_q   <= 1'b0;
              drain_q <= DCW'(LAT - 1);
            end else if (last_col_d) begin
              j_q     <= '0;
              i_q     <= i_q + DIMLEN'(1);
              rrow_q  <= row_next_d;
              raddr_q <= row_next_d;
            end else begin
              j_q     <= j_q + DIMLEN'(1);
              raddr_q <= raddr_q + ADDRLEN'(1);
            end
          end
        end
        S_DRAIN: begin
          // Leave once only the final write remains in the last stage.
          if (drain_q == '0) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            drain_q <= drain_q - DCW'(1);
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int k = 0; k < LAT; k++) begin
        wa_q[k] <= '0;
      end
    end else begin
      vld_q[0] <= issue_d;
      wa_q[0]  <= raddr_q + off_q;
      for (int k = 1; k < LAT; k++) begin
        vld_q[k] <= vld_q[k-1];
        wa_q[k]  <= wa_q[k-1];
      end
    end
  end

  assign rd_en     = issue_d;
  assign rd_addr   = raddr_q;
  assign wr_en     = vld_q[LAT-1];
  assign wr_addr   = wa_q[LAT-1];
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign win_count = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_gaussian_window_ctrl.sv
`default_nettype none
// tb_gaussian_window_ctrl : randomized bench comparing per-cycle traces of the
// window controller against a raster-order reference model.
module tb_gaussian_window_ctrl;

  localparam int AW     = 21;
  localparam int DW     = 11;
  localparam int K      = 3;
  localparam int RDL    = 1;
  localparam int CL     = 1;
  localparam int CW     = 21;
  localparam int LATM   = RDL + CL;
  localparam int HALFM  = (K - 1) / 2;
  localparam int MASK   = (1 << AW) - 1;
  localparam int BUDGET = 400;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          pause;
  logic [DW-1:0] cfg_rows;
  logic [DW-1:0] cfg_cols;
  logic [AW-1:0] cfg_rd_base;
  logic [AW-1:0] cfg_wr_base;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic          busy;
  logic          done;
  logic          err;
  logic [CW-1:0] win_count;

  always #5 clk = ~clk;

  gaussian_window_ctrl #(
    .ADDRLEN(AW), .DIMLEN(DW), .KSIZE(K), .RD_LAT(RDL), .CORE_LAT(CL), .CNTLEN(CW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause),
    .cfg_rows(cfg_rows), .cfg_cols(cfg_cols),
    .cfg_rd_base(cfg_rd_base), .cfg_wr_base(cfg_wr_base),
    .rd_en(rd_en), .rd_addr(rd_addr), .wr_en(wr_en), .wr_addr(wr_addr),
    .busy(busy), .done(done), .err(err), .win_count(win_count)
  );

  int checks   = 0;
  int failures = 0;

  int pz     [BUDGET];
  int obs_re [BUDGET];
  int obs_ra [BUDGET];
  int obs_we [BUDGET];
  int obs_wa [BUDGET];
  int obs_bz [BUDGET];
  int exp_re [BUDGET];
  int exp_ra [BUDGET];
  int exp_we [BUDGET];
  int exp_wa [BUDGET];
  int exp_bz [BUDGET];
  int done_cyc, done_err, done_cnt, rst_cyc;
  int exp_n, exp_done, exp_valid;

  // pmode: 0 no pause, 1 pause window [pa, pa+pl), 2 random pause.
  task automatic run_frame(input int rows, input int cols, input int rb, input int wb,
                           input int pmode, input int pa, input int pl,
                           input int s1, input int s2, input int rst_at);
    int nreads;
    for (int x = 0; x < BUDGET; x++) begin
      pz[x] = 0; obs_re[x] = 0; obs_ra[x] = 0; obs_we[x] = 0; obs_wa[x] = 0; obs_bz[x] = 0;
    end
    done_cyc = -1; rst_cyc = -1; done_err = 0; done_cnt = 0; nreads = 0;
    @(posedge clk); #1;
    cfg_rows = DW'(rows); cfg_cols = DW'(cols);
    cfg_rd_base = AW'(rb); cfg_wr_base = AW'(wb);
    start = 1'b1; pause = 1'b0;
    for (int c = 0; c < BUDGET - 1; c++) begin
      @(negedge clk);
      obs_re[c] = int'(rd_en); obs_ra[c] = int'(rd_addr);
      obs_we[c] = int'(wr_en); obs_wa[c] = int'(wr_addr);
      obs_bz[c] = int'(busy);
      if (rd_en) nreads++;
      if (done) begin
        done_cyc = c; done_err = int'(err); done_cnt = int'(win_count);
        break;
      end
      if (rst_at > 0 && nreads == rst_at) begin
        rst = 1'b1; rst_cyc = c;
        break;
      end
      @(posedge clk); #1;
      start       = (c + 1 == s1 || c + 1 == s2);
      cfg_rows    = DW'($urandom_range(0, 2047));
      cfg_cols    = DW'($urandom_range(0, 2047));
      cfg_rd_base = AW'($urandom_range(0, MASK));
      cfg_wr_base = AW'($urandom_range(0, MASK));
      if (pmode == 1)      pause = (c + 1 >= pa && c + 1 < pa + pl);
      else if (pmode == 2) pause = ($urandom_range(0, 9) < 3);
      else                 pause = 1'b0;
      pz[c+1] = int'(pause);
    end
    start = 1'b0;
  endtask

  // Windows visited in raster order; each taken on the next unpaused cycle.
  task automatic model_frame(input int rows, input int cols, input int rb, input int wb);
    int k, ri, cj;
    for (int x = 0; x < BUDGET; x++) begin
      exp_re[x] = 0; exp_ra[x] = 0; exp_we[x] = 0; exp_wa[x] = 0; exp_bz[x] = 0;
    end
    exp_valid = (rows >= K && cols >= K) ? 1 : 0;
    exp_n     = exp_valid ? (rows - K + 1) * (cols - K + 1) : 0;
    exp_done  = 1;
    k = 0;
    for (int c = 1; c < BUDGET - LATM - 1 && k < exp_n; c++) begin
      if (pz[c] == 0) begin
        ri = k / (cols - K + 1);
        cj = k % (cols - K + 1);
        exp_re[c] = 1;
        exp_ra[c] = (rb + ri * cols + cj) & MASK;
        exp_we[c+LATM] = 1;
        exp_wa[c+LATM] = (wb + (ri + HALFM) * cols + cj + HALFM) & MASK;
        exp_done = c + LATM + 1;
        k++;
      end
    end
    for (int c = 1; c < exp_done; c++) exp_bz[c] = 1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; pause = 1'b0;
    cfg_rows = '0; cfg_cols = '0; cfg_rd_base = '0; cfg_wr_base = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({rd_en, rd_addr, wr_en, wr_addr, busy, done, err, win_count} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got %h, required 0",
               {rd_en, rd_addr, wr_en, wr_addr, busy, done, err, win_count});
    end
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({rd_en, wr_en, busy, done} !== 4'b0) begin
      failures++;
      $display("FAIL idle_after_reset: rd_en/wr_en/busy/done=%b, required 0000",
               {rd_en, wr_en, busy, done});
    end
  endtask

  task automatic test_basic_frame();
    int bad;
    run_frame(8, 8, 0, 100, 0, 0, 0, -1, -1, 0);
    model_frame(8, 8, 0, 100);
    bad = -1;
    for (int c = 0; c < BUDGET; c++)
      if (bad < 0 && (obs_re[c] != exp_re[c] || (exp_re[c] == 1 && obs_ra[c] != exp_ra[c]))) bad = c;
    checks++;
    if (bad >= 0) begin
      failures++;
      $display("FAIL basic_reads: cycle %0d rd_en=%0d addr=%0d, required rd_en=%0d addr=%0d",
               bad, obs_re[bad], obs_ra[bad], exp_re[bad], exp_ra[bad]);
    end
    bad = -1;
    for (int c = 0; c < BUDGET; c++)
      if (bad < 0 && (obs_we[c] != exp_we[c] || (exp_we[c] == 1 && obs_wa[c] != exp_wa[c]))) bad = c;
    checks++;
    if (bad >= 0) begin
      failures++;
      $display("FAIL basic_writes: cycle %0d wr_en=%0d addr=%0d, required wr_en=%0d addr=%0d",
               bad, obs_we[bad], obs_wa[bad], exp_we[bad], exp_wa[bad]);
    end
    bad = -1;
    for (int c = 0; c < BUDGET; c++) if (bad < 0 && obs_bz[c] != exp_bz[c]) bad = c;
    checks++;
    if (bad >= 0) begin
      failures++;
      $display("FAIL basic_busy: cycle %0d busy=%0d, required %0d", bad, obs_bz[bad], exp_bz[bad]);
    end
    checks++;
    if (obs_ra[1] != 0 || obs_ra[7] != 8 || obs_ra[36] != 45 || obs_re[36] != 1 || obs_re[37] != 0) begin
      failures++;
      $display("FAIL basic_plan_reads: addr@1=%0d addr@7=%0d addr@36=%0d en@36=%0d en@37=%0d, required 0 8 45 1 0",
               obs_ra[1], obs_ra[7], obs_ra[36], obs_re[36], obs_re[37]);
    end
    checks++;
    if (obs_wa[3] != 109 || obs_wa[38] != 154 || obs_we[2] != 0 || obs_we[39] != 0) begin
      failures++;
      $display("FAIL basic_plan_writes: addr@3=%0d addr@38=%0d en@2=%0d en@39=%0d, required 109 154 0 0",
               obs_wa[3], obs_wa[38], obs_we[2], obs_we[39]);
    end
    checks++;
    if (done_cyc != 39 || done_cnt != 36 || done_err != 0) begin
      failures++;
      $display("FAIL basic_done: cycle=%0d count=%0d err=%0d, required 39 36 0", done_cyc, done_cnt, done_err);
    end
  endtask

  task automatic test_pause();
    int bad;
    run_frame(8, 8, 0, 100, 1, 12, 4, -1, -1, 0);
    model_frame(8, 8, 0, 100);
    bad = -1;
    for (int c = 0; c < BUDGET; c++)
      if (bad < 0 && (obs_re[c] != exp_re[c] || (exp_re[c] == 1 && obs_ra[c] != exp_ra[c]) ||
                      obs_we[c] != exp_we[c] || (exp_we[c] == 1 && obs_wa[c] != exp_wa[c]))) bad = c;
    checks++;
    if (bad >= 0) begin
      failures++;
      $display("FAIL pause_trace: cycle %0d rd=%0d/%0d wr=%0d/%0d, required rd=%0d/%0d wr=%0d/%0d",
               bad, obs_re[bad], obs_ra[bad], obs_we[bad], obs_wa[bad],
               exp_re[bad], exp_ra[bad], exp_we[bad], exp_wa[bad]);
    end
    bad = -1;
    for (int c = 12; c < 16; c++) if (bad < 0 && obs_ra[c] != exp_ra[16]) bad = c;
    checks++;
    if (bad >= 0) begin
      failures++;
      $display("FAIL pause_hold_addr: cycle %0d rd_addr=%0d, required %0d", bad, obs_ra[bad], exp_ra[16]);
    end
    checks++;
    if (done_cyc != 43 || done_cnt != 36) begin
      failures++;
      $display("FAIL pause_done: cycle=%0d count=%0d, required 43 36", done_cyc, done_cnt);
    end
  endtask

  task automatic test_too_small();
    int bad;
    run_frame(2, 8, 5, 50, 0, 0, 0, -1, -1, 0);
    bad = -1;
    for (int c = 0; c < BUDGET; c++) if (bad < 0 && (obs_re[c] != 0 || obs_we[c] != 0)) bad = c;
    checks++;
    if (bad >= 0) begin
      failures++;
      $display("FAIL small_no_access: cycle %0d rd_en=%0d wr_en=%0d, required 0 0", bad, obs_re[bad], obs_we[bad]);
    end
    checks++;
    if (done_cyc != 1 || done_err != 1 || done_cnt != 0) begin
      failures++;
      $display("FAIL small_done: cycle=%0d err=%0d count=%0d, required 1 1 0", done_cyc, done_err, done_cnt);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL small_err_held: err=%b busy=%b, required 1 0", err, busy);
    end
  endtask

  task automatic test_exact_fit();
    int wb, bad;
    wb = int'($urandom_range(0, MASK));
    run_frame(3, 3, 0, wb, 0, 0, 0, -1, -1, 0);
    model_frame(3, 3, 0, wb);
    bad = -1;
    for (int c = 0; c < BUDGET; c++)
      if (bad < 0 && (obs_re[c] != exp_re[c] || (exp_re[c] == 1 && obs_ra[c] != exp_ra[c]) ||
                      obs_we[c] != exp_we[c] || (exp_we[c] == 1 && obs_wa[c] != exp_wa[c]))) bad = c;
    checks++;
    if (bad >= 0) begin
      failures++;
      $display("FAIL exact_trace: cycle %0d rd=%0d/%0d wr=%0d/%0d, required rd=%0d/%0d wr=%0d/%0d",
               bad, obs_re[bad], obs_ra[bad], obs_we[bad], obs_wa[bad],
               exp_re[bad], exp_ra[bad], exp_we[bad], exp_wa[bad]);
    end
    checks++;
    if (obs_ra[1] != 0 || obs_wa[3] != ((wb + 4) & MASK) || done_cnt != 1 || done_err != 0) begin
      failures++;
      $display("FAIL exact_plan: rd_addr=%0d wr_addr=%0d count=%0d err=%0d, required 0 %0d 1 0",
               obs_ra[1], obs_wa[3], done_cnt, done_err, (wb + 4) & MASK);
    end
  endtask

  task automatic test_reset_midframe();
    int bad, rb, wb;
    run_frame(8, 8, 200, 300, 0, 0, 0, -1, -1, 10);
    checks++;
    if (rst_cyc != 10) begin
      failures++;
      $display("FAIL midrst_reads: tenth read at cycle %0d, required 10", rst_cyc);
    end
    pause = 1'b0;
    @(negedge clk);
    checks++;
    if ({rd_en, rd_addr, wr_en, wr_addr, busy, done, err, win_count} !== '0) begin
      failures++;
      $display("FAIL midrst_outputs: got %h, required 0",
               {rd_en, rd_addr, wr_en, wr_addr, busy, done, err, win_count});
    end
    @(posedge clk); #1 rst = 1'b0;
    bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (rd_en !== 1'b0 || wr_en !== 1'b0 || done !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL midrst_quiet: %0d active cycles after reset, required 0", bad);
    end
    rb = int'($urandom_range(0, MASK));
    wb = int'($urandom_range(0, MASK));
    run_frame(6, 7, rb, wb, 2, 0, 0, -1, -1, 0);
    model_frame(6, 7, rb, wb);
    bad = -1;
    for (int c = 0; c < BUDGET; c++)
      if (bad < 0 && (obs_re[c] != exp_re[c] || (exp_re[c] == 1 && obs_ra[c] != exp_ra[c]) ||
                      obs_we[c] != exp_we[c] || (exp_we[c] == 1 && obs_wa[c] != exp_wa[c]))) bad = c;
    checks++;
    if (bad >= 0) begin
      failures++;
      $display("FAIL midrst_rerun: cycle %0d rd=%0d/%0d wr=%0d/%0d, required rd=%0d/%0d wr=%0d/%0d",
               bad, obs_re[bad], obs_ra[bad], obs_we[bad], obs_wa[bad],
               exp_re[bad], exp_ra[bad], exp_we[bad], exp_wa[bad]);
    end
    checks++;
    if (done_cyc != exp_done || done_cnt != 20) begin
      failures++;
      $display("FAIL midrst_rerun_done: cycle=%0d count=%0d, required %0d 20", done_cyc, done_cnt, exp_done);
    end
  endtask

  task automatic test_start_ignored();
    int bad;
    run_frame(8, 8, 1000, 5000, 0, 0, 0, 10, 37, 0);
    model_frame(8, 8, 1000, 5000);
    bad = -1;
    for (int c = 0; c < BUDGET; c++)
      if (bad < 0 && (obs_re[c] != exp_re[c] || (exp_re[c] == 1 && obs_ra[c] != exp_ra[c]) ||
                      obs_we[c] != exp_we[c] || (exp_we[c] == 1 && obs_wa[c] != exp_wa[c]) ||
                      obs_bz[c] != exp_bz[c])) bad = c;
    checks++;
    if (bad >= 0) begin
      failures++;
      $display("FAIL start_ignored_trace: cycle %0d rd=%0d/%0d wr=%0d/%0d busy=%0d, required rd=%0d/%0d wr=%0d/%0d busy=%0d",
               bad, obs_re[bad], obs_ra[bad], obs_we[bad], obs_wa[bad], obs_bz[bad],
               exp_re[bad], exp_ra[bad], exp_we[bad], exp_wa[bad], exp_bz[bad]);
    end
    checks++;
    if (done_cyc != 39 || done_cnt != 36) begin
      failures++;
      $display("FAIL start_ignored_done: cycle=%0d count=%0d, required 39 36", done_cyc, done_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int bad;
    run_frame(4, 5, 77, 999, 2, 0, 0, -1, -1, 0);
    model_frame(4, 5, 77, 999);
    bad = -1;
    for (int c = 0; c < BUDGET; c++)
      if (bad < 0 && (obs_re[c] != exp_re[c] || (exp_re[c] == 1 && obs_ra[c] != exp_ra[c]) ||
                      obs_we[c] != exp_we[c] || (exp_we[c] == 1 && obs_wa[c] != exp_wa[c]))) bad = c;
    checks++;
    if (bad >= 0) begin
      failures++;
      $display("FAIL b2b_trace: cycle %0d rd=%0d/%0d wr=%0d/%0d, required rd=%0d/%0d wr=%0d/%0d",
               bad, obs_re[bad], obs_ra[bad], obs_we[bad], obs_wa[bad],
               exp_re[bad], exp_ra[bad], exp_we[bad], exp_wa[bad]);
    end
    checks++;
    if (done_cyc != exp_done || done_cnt != 6) begin
      failures++;
      $display("FAIL b2b_done: cycle=%0d count=%0d, required %0d 6", done_cyc, done_cnt, exp_done);
    end
  endtask

  task automatic test_random_frames();
    int rows, cols, rb, wb, bad;
    for (int n = 0; n < 8; n++) begin
      rows = int'($urandom_range(2, 12));
      cols = int'($urandom_range(2, 12));
      rb   = int'($urandom_range(0, MASK));
      wb   = int'($urandom_range(0, MASK));
      run_frame(rows, cols, rb, wb, 2, 0, 0, -1, -1, 0);
      model_frame(rows, cols, rb, wb);
      bad = -1;
      for (int c = 0; c < BUDGET; c++)
        if (bad < 0 && (obs_re[c] != exp_re[c] || (exp_re[c] == 1 && obs_ra[c] != exp_ra[c]) ||
                        obs_we[c] != exp_we[c] || (exp_we[c] == 1 && obs_wa[c] != exp_wa[c]) ||
                        obs_bz[c] != exp_bz[c])) bad = c;
      checks++;
      if (bad >= 0) begin
        failures++;
        $display("FAIL rand_trace[%0d] %0dx%0d: cycle %0d rd=%0d/%0d wr=%0d/%0d busy=%0d, required rd=%0d/%0d wr=%0d/%0d busy=%0d",
                 n, rows, cols, bad, obs_re[bad], obs_ra[bad], obs_we[bad], obs_wa[bad], obs_bz[bad],
                 exp_re[bad], exp_ra[bad], exp_we[bad], exp_wa[bad], exp_bz[bad]);
      end
      checks++;
      if (done_cyc != exp_done || done_cnt != exp_n || done_err != 1 - exp_valid) begin
        failures++;
        $display("FAIL rand_done[%0d] %0dx%0d: cycle=%0d count=%0d err=%0d, required %0d %0d %0d",
                 n, rows, cols, done_cyc, done_cnt, done_err, exp_done, exp_n, 1 - exp_valid);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic_frame();
    test_pause();
    test_too_small();
    test_exact_fit();
    test_reset_midframe();
    test_start_ignored();
    test_back_to_back();
    test_random_frames();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
